// File: rtl/croc_pkg.sv
// Shared OBI manager request/response types and the user-domain arbiter state encoding.
package croc_pkg;

    localparam int unsigned ObiAidW = 4;

    typedef struct packed {
        logic               req;
        logic [31:0]        addr;
        logic               we;
        logic [3:0]         be;
        logic [31:0]        wdata;
        logic [ObiAidW-1:0] aid;
    } mgr_obi_req_t;

    typedef struct packed {
        logic               gnt;
        logic               rvalid;
        logic [31:0]        rdata;
        logic               err;
        logic [ObiAidW-1:0] rid;
    } mgr_obi_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } user_obi_arb_state_e;

endpackage

// File: rtl/user_obi_rr_pick.sv
// Combinational round-robin search: first asserted request at or after rr_i+1, wrapping.
module user_obi_rr_pick #(
    parameter int unsigned NumMgr = 2,
    parameter int unsigned IdxW   = $clog2(NumMgr)
) (
    input  logic [NumMgr-1:0] req_i,
    input  logic [IdxW-1:0]   rr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [IdxW-1:0] cand;

    // Walk from the farthest offset down so the nearest hit after rr_i wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = int'(NumMgr); i >= 1; i--) begin
            cand = IdxW'((int'(rr_i) + i) % int'(NumMgr));
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_obi_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NumMgr requesters, one outstanding txn.
// Optional response watchdog enabled by defining USER_OBI_ARB_TIMEOUT_EN.
module user_obi_arbiter
    import croc_pkg::*;
#(
    parameter int unsigned NumMgr        = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  mgr_obi_req_t [NumMgr-1:0] mgr_req_i,
    output mgr_obi_rsp_t [NumMgr-1:0] mgr_rsp_o,
    output mgr_obi_req_t              obi_req_o,
    input  mgr_obi_rsp_t              obi_rsp_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int unsigned IdxW = $clog2(NumMgr);

    if (NumMgr < 2) begin : g_chk_num
        $error("user_obi_arbiter: NumMgr must be at least 2");
    end
    if (TimeoutCycles < 1) begin : g_chk_tmo
        $error("user_obi_arbiter: TimeoutCycles must be at least 1");
    end

    user_obi_arb_state_e state_q;
    logic [IdxW-1:0]     sel_q, rr_q, rsp_idx_q;
    logic [NumMgr-1:0]   req_vec;
    logic [IdxW-1:0]     pick_idx, cur_idx;
    logic                pick_vld, fwd, gnt_evt, rsp_ok, drop, expire;

    for (genvar g = 0; g < int'(NumMgr); g++) begin : g_req_vec
        assign req_vec[g] = mgr_req_i[g].req;
    end

    user_obi_rr_pick #(.NumMgr(NumMgr), .IdxW(IdxW)) u_pick (
        .req_i   (req_vec),
        .rr_i    (rr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

`ifdef USER_OBI_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0]    cnt_q;
    logic [ObiAidW-1:0] aid_q;
    logic               stale_q;

    // The first rvalid after a timeout belongs to the abandoned transaction.
    assign drop   = stale_q && obi_rsp_i.rvalid;
    assign expire = (state_q == ARB_RSP) && (cnt_q == CntW'(TimeoutCycles)) && !rsp_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            aid_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            if (gnt_evt) begin
                cnt_q <= '0;
                aid_q <= obi_req_o.aid;
            end else if (state_q == ARB_RSP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expire)    stale_q <= 1'b1;
            else if (drop) stale_q <= 1'b0;
        end
    end
`else
    assign drop   = 1'b0;
    assign expire = 1'b0;
`endif

    assign rsp_ok    = (state_q == ARB_RSP) && obi_rsp_i.rvalid && !drop;
    assign busy_o    = (state_q != ARB_IDLE);
    assign timeout_o = expire;

    always_comb begin
        obi_req_o = '0;
        mgr_rsp_o = '0;
        cur_idx   = (state_q == ARB_REQ) ? sel_q : pick_idx;
        fwd       = rst_ni && (((state_q == ARB_IDLE) && pick_vld) || (state_q == ARB_REQ));
        if (fwd) obi_req_o = mgr_req_i[cur_idx];
        gnt_evt = fwd && obi_rsp_i.gnt;
        if (gnt_evt) mgr_rsp_o[cur_idx].gnt = 1'b1;
        if (rsp_ok) begin
            mgr_rsp_o[rsp_idx_q].rvalid = 1'b1;
            mgr_rsp_o[rsp_idx_q].rdata  = obi_rsp_i.rdata;
            mgr_rsp_o[rsp_idx_q].err    = obi_rsp_i.err;
            mgr_rsp_o[rsp_idx_q].rid    = obi_rsp_i.rid;
        end else if (expire) begin
            mgr_rsp_o[rsp_idx_q].rvalid = 1'b1;
            mgr_rsp_o[rsp_idx_q].err    = 1'b1;
`ifdef USER_OBI_ARB_TIMEOUT_EN
            mgr_rsp_o[rsp_idx_q].rid    = aid_q;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            sel_q     <= '0;
            rr_q      <= IdxW'(NumMgr - 1);
            rsp_idx_q <= '0;
        end else begin
            if (gnt_evt) begin
                rr_q      <= cur_idx;
                rsp_idx_q <= cur_idx;
            end
            unique case (state_q)
                ARB_IDLE: begin
                    if (gnt_evt) begin
                        state_q <= ARB_RSP;
                    end else if (pick_vld) begin
                        state_q <= ARB_REQ;
                        sel_q   <= pick_idx;
                    end
                end
                ARB_REQ:  if (gnt_evt) state_q <= ARB_RSP;
                ARB_RSP:  if (rsp_ok || expire) state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule
